// File: rtl/bios_shadow_loader.sv
`timescale 1ns/1ps
// bios_shadow_loader: boot-time Wishbone master that shadows the BIOS ROM into RAM,
// keeping the CPU in reset until every word has been copied and checksummed.
module bios_shadow_loader #(
    parameter int unsigned WORDS    = 128,
    parameter logic [18:0] SRC_BASE = 19'h7FF80,
    parameter logic [18:0] DST_BASE = 19'h7F800,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        restart_i,
    output logic [19:1] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    output logic        m_tga_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_o,
    output logic [15:0] checksum_o
);

    typedef enum logic [2:0] {
        IDLE, RD, RD_GAP, WR, WR_GAP, DONE, ERROR
    } LoaderState;

    localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);

    LoaderState  r_state;
    LoaderState  w_nextState;
    logic [15:0] r_idx;
    logic [15:0] w_nextIdx;
    logic [7:0]  r_timer;
    logic        w_timedOut;
    logic        w_busCycle;
    logic [18:0] w_srcAdr;
    logic [18:0] w_dstAdr;

    assign w_timedOut = (r_timer == TIMEOUT - 8'd1);
    assign w_busCycle = (w_nextState == RD) || (w_nextState == WR);
    assign w_srcAdr   = SRC_BASE + {3'b000, w_nextIdx};
    assign w_dstAdr   = DST_BASE + {3'b000, w_nextIdx};
    assign m_tga_o    = 1'b0;

    // Acks are only honoured while strobing, so the ROM's trailing ack in RD_GAP is dropped.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        case (r_state)
            IDLE:   w_nextState = RD;
            RD: begin
                if (m_ack_i)         w_nextState = RD_GAP;
                else if (w_timedOut) w_nextState = ERROR;
            end
            RD_GAP: w_nextState = WR;
            WR: begin
                if (m_ack_i)         w_nextState = WR_GAP;
                else if (w_timedOut) w_nextState = ERROR;
            end
            WR_GAP: begin
                if (r_idx == LAST_IDX) begin
                    w_nextState = DONE;
                end else begin
                    w_nextIdx   = r_idx + 16'd1;
                    w_nextState = RD;
                end
            end
            DONE, ERROR: begin
                if (restart_i) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        if (w_nextState == IDLE) w_nextIdx = '0;
    end

    // Every output is registered from the next-state decode so it lines up with the state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            m_we_o     <= 1'b0;
            m_sel_o    <= 2'b00;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            cpu_rst_o  <= 1'b1;
            checksum_o <= '0;
        end else begin
            r_state   <= w_nextState;
            r_idx     <= w_nextIdx;
            m_cyc_o   <= w_busCycle;
            m_stb_o   <= w_busCycle;
            m_we_o    <= (w_nextState == WR);
            m_sel_o   <= w_busCycle ? 2'b11 : 2'b00;
            busy_o    <= (w_nextState != DONE) && (w_nextState != ERROR);
            done_o    <= (w_nextState == DONE);
            err_o     <= (w_nextState == ERROR);
            cpu_rst_o <= (w_nextState != DONE);

            if (w_nextState == RD)      m_adr_o <= w_srcAdr;
            else if (w_nextState == WR) m_adr_o <= w_dstAdr;

            if (w_nextState != r_state)                r_timer <= '0;
            else if ((r_state == RD) || (r_state == WR)) r_timer <= r_timer + 8'd1;

            if ((r_state == RD) && m_ack_i) m_dat_o <= m_dat_i;

            if (w_nextState == IDLE)             checksum_o <= '0;
            else if ((r_state == RD) && m_ack_i) checksum_o <= checksum_o + m_dat_i;
        end
    end

endmodule

// File: tb/tb_bios_shadow_loader.sv
`timescale 1ns/1ps
// Directed bench for bios_shadow_loader: a 128-word instance against ROM/RAM models
// and a one-word instance against a slave with programmable ack latency.
module tb_bios_shadow_loader;

    localparam logic [18:0] SRC = 19'h7FF80;
    localparam logic [18:0] DST = 19'h7F800;

    logic        clock = 1'b0;
    logic        rstN, rstBN, restartA, restartB;
    logic [19:1] adrA, adrB;
    logic [15:0] datOA, datIA, datOB, datIB, chkA, chkB;
    logic        weA, tgaA, cycA, stbA, ackA, busyA, doneA, errA, cpuRstA;
    logic        weB, tgaB, cycB, stbB, ackB, busyB, doneB, errB, cpuRstB;
    logic [1:0]  selA, selB;

    always #5 clock = ~clock;

    bios_shadow_loader dutA (
        .wb_clk_i(clock), .wb_rst_i(rstN), .restart_i(restartA),
        .m_adr_o(adrA), .m_dat_o(datOA), .m_dat_i(datIA), .m_we_o(weA),
        .m_sel_o(selA), .m_tga_o(tgaA), .m_cyc_o(cycA), .m_stb_o(stbA),
        .m_ack_i(ackA), .busy_o(busyA), .done_o(doneA), .err_o(errA),
        .cpu_rst_o(cpuRstA), .checksum_o(chkA)
    );

    bios_shadow_loader #(.WORDS(1)) dutB (
        .wb_clk_i(clock), .wb_rst_i(rstBN), .restart_i(restartB),
        .m_adr_o(adrB), .m_dat_o(datOB), .m_dat_i(datIB), .m_we_o(weB),
        .m_sel_o(selB), .m_tga_o(tgaB), .m_cyc_o(cycB), .m_stb_o(stbB),
        .m_ack_i(ackB), .busy_o(busyB), .done_o(doneB), .err_o(errB),
        .cpu_rst_o(cpuRstB), .checksum_o(chkB)
    );

    // Slave models: ack after 'latency' strobed cycles; the ROM repeats its ack once after stb drops.
    logic [15:0] rom [0:127];
    logic [15:0] ram [0:127];
    logic [18:0] romOff, ramOff, hangOff;
    logic        ackNow, linger = 1'b0, hangOn, randLat;
    int          cycleCnt = 0, stbCycles = 0, latency = 1;
    int          writeCount = 0, readCount = 0, badCount = 0;
    logic [15:0] romB, ramB;
    int          latB, stbCyclesB = 0, writesB = 0, readsB = 0;

    assign romOff = adrA - SRC;
    assign ramOff = adrA - DST;
    assign datIA  = (romOff < 19'd128) ? rom[romOff[6:0]] : 16'h0000;
    assign ackNow = cycA && stbA && (stbCycles == latency) && !(weA && hangOn && ramOff == hangOff);
    assign ackA   = ackNow || linger;
    assign datIB  = (adrB == SRC) ? romB : 16'h0000;
    assign ackB   = cycB && stbB && (stbCyclesB == latB);

    always @(posedge clock) begin
        cycleCnt <= cycleCnt + 1;
        linger   <= ackNow && !weA;
        if (cycA && stbA && !ackNow) stbCycles <= stbCycles + 1;
        else                         stbCycles <= 0;
        if (ackNow) begin
            latency <= randLat ? int'($urandom_range(0, 4)) : 1;
            if (weA) begin
                writeCount <= writeCount + 1;
                if (ramOff < 19'd128) ram[ramOff[6:0]] <= datOA;
                else                  badCount <= badCount + 1;
            end else begin
                readCount <= readCount + 1;
                if (!(romOff < 19'd128)) badCount <= badCount + 1;
            end
        end
        if (cycB && stbB && !ackB) stbCyclesB <= stbCyclesB + 1;
        else                       stbCyclesB <= 0;
        if (ackB) begin
            if (weB) begin
                writesB <= writesB + 1;
                if (adrB == DST) ramB <= datOB;
            end else begin
                readsB <= readsB + 1;
            end
        end
    end

    int compared = 0, mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit onB, output int base);
        @(negedge clock);
        if (onB) restartB = 1'b1;
        else     restartA = 1'b1;
        base = cycleCnt;
        @(negedge clock);
        restartA = 1'b0;
        restartB = 1'b0;
    endtask

    task automatic waitDone(input bit onB, input int limit, input int base,
                            output int elapsed, output logic rstBefore);
        int n = 0;
        rstBefore = 1'bx;
        while ((onB ? doneB : doneA) !== 1'b1 && n < limit) begin
            rstBefore = onB ? cpuRstB : cpuRstA;
            @(negedge clock);
            n++;
        end
        elapsed = cycleCnt - base;
    endtask

    task automatic waitWrite(input int idx, input int limit);
        int n = 0;
        while (!(stbA && weA && adrA == DST + 19'(idx)) && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput($sformatf("reachWrite%0d", idx), 32'(n < limit), 1);
    endtask

    task automatic checkRam(input string tag);
        int bad = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== rom[i]) bad++;
        checkOutput(tag, bad, 0);
    endtask

    int          base, elapsed, wrBase, rdBase, wEntry, eCycle, n;
    logic        rstBefore;
    logic [15:0] expSum;

    initial begin
        rstN = 1'b0; rstBN = 1'b0; restartA = 1'b0; restartB = 1'b0;
        hangOn = 1'b0; hangOff = '0; randLat = 1'b0; romB = 16'hBEEF; latB = 3;
        for (int i = 0; i < 128; i++) rom[i] = 16'(i * 3 + 1);

        repeat (2) @(negedge clock);
        checkOutput("rstCpuRst", cpuRstA, 1);
        checkOutput("rstCyc", cycA, 0);
        checkOutput("rstStb", stbA, 0);
        checkOutput("rstWe", weA, 0);
        checkOutput("rstTga", tgaA, 0);
        checkOutput("rstSel", selA, 0);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDone", doneA, 0);
        checkOutput("rstErr", errA, 0);
        checkOutput("rstChk", chkA, 0);
        checkOutput("rstAdr", adrA, 0);
        checkOutput("rstDat", datOA, 0);

        // Nominal copy with exact per-word timing
        rstN = 1'b1;
        base = cycleCnt; wrBase = writeCount; rdBase = readCount;
        @(negedge clock);
        checkOutput("c1Adr", adrA, SRC);
        checkOutput("c1Stb", {cycA, stbA, weA}, 3'b110);
        checkOutput("c1Sel", selA, 2'b11);
        checkOutput("c1Busy", busyA, 1);
        repeat (3) @(negedge clock);
        checkOutput("c4Adr", adrA, DST);
        checkOutput("c4Stb", {cycA, stbA, weA}, 3'b111);
        checkOutput("c4Dat", datOA, 16'h0001);
        checkOutput("c4Chk", chkA, 16'h0001);
        repeat (2) @(negedge clock);
        checkOutput("c6Gap", {cycA, stbA}, 2'b00);
        @(negedge clock);
        checkOutput("c7Adr", adrA, SRC + 19'd1);
        checkOutput("c7Stb", {cycA, stbA, weA}, 3'b110);
        waitDone(1'b0, 2000, base, elapsed, rstBefore);
        checkOutput("nomDoneCycle", elapsed, 769);
        checkOutput("nomDone", doneA, 1);
        checkOutput("nomCpuRst", cpuRstA, 0);
        checkOutput("nomCpuRstBefore", rstBefore, 1);
        checkOutput("nomBusy", busyA, 0);
        checkOutput("nomChk", chkA, 16'd24512);
        checkOutput("nomWrites", writeCount - wrBase, 128);
        checkOutput("nomReads", readCount - rdBase, 128);
        checkRam("nomRam");

        // Restart from DONE, then a mid-copy restart that must be ignored
        for (int i = 0; i < 128; i++) rom[i] = 16'(i * 5 + 7);
        wrBase = writeCount;
        applyStimulus(1'b0, base);
        checkOutput("rsBusy", busyA, 1);
        checkOutput("rsCpuRst", cpuRstA, 1);
        checkOutput("rsDone", doneA, 0);
        checkOutput("rsChk", chkA, 0);
        repeat (300) @(negedge clock);
        restartA = 1'b1;
        @(negedge clock);
        restartA = 1'b0;
        checkOutput("midRestartBusy", busyA, 1);
        waitDone(1'b0, 2000, base, elapsed, rstBefore);
        checkOutput("rsDoneCycle", elapsed, 770);
        checkOutput("rsChkFinal", chkA, 16'd41536);
        checkOutput("rsWrites", writeCount - wrBase, 128);
        checkRam("rsRam");

        // RAM never acks the write at index 5
        for (int i = 0; i < 128; i++) rom[i] = 16'(i * 3 + 1);
        hangOn = 1'b1; hangOff = 19'd5; wrBase = writeCount;
        applyStimulus(1'b0, base);
        waitWrite(5, 200);
        wEntry = cycleCnt;
        n = 0;
        while (errA !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        eCycle = cycleCnt;
        checkOutput("toLatency", eCycle - wEntry, 255);
        checkOutput("toBus", {cycA, stbA}, 2'b00);
        checkOutput("toCpuRst", cpuRstA, 1);
        checkOutput("toDone", doneA, 0);
        checkOutput("toChk", chkA, 16'd51);
        checkOutput("toWrites", writeCount - wrBase, 5);
        repeat (5) @(negedge clock);
        checkOutput("toErrHeld", errA, 1);

        hangOn = 1'b0;
        applyStimulus(1'b0, base);
        checkOutput("reErrClear", errA, 0);
        checkOutput("reBusy", busyA, 1);
        checkOutput("reChkZero", chkA, 0);
        waitDone(1'b0, 2000, base, elapsed, rstBefore);
        checkOutput("reDoneCycle", elapsed, 770);
        checkOutput("reChk", chkA, 16'd24512);
        checkRam("reRam");

        // Asynchronous reset while writing index 60
        for (int i = 0; i < 128; i++) rom[i] = 16'(i * 7 + 3);
        applyStimulus(1'b0, base);
        waitWrite(60, 1000);
        #3 rstN = 1'b0;
        #1;
        checkOutput("arBus", {cycA, stbA, weA, selA}, 5'b00000);
        checkOutput("arAdr", adrA, 0);
        checkOutput("arDat", datOA, 0);
        checkOutput("arChk", chkA, 0);
        checkOutput("arCpuBusy", {cpuRstA, busyA, doneA}, 3'b100);
        repeat (3) @(negedge clock);
        rstN = 1'b1;
        base = cycleCnt;
        @(negedge clock);
        checkOutput("arRestartAdr", adrA, SRC);
        waitDone(1'b0, 2000, base, elapsed, rstBefore);
        checkOutput("arDoneCycle", elapsed, 769);
        checkOutput("arChk", chkA, 16'd57280);
        checkRam("arRam");

        // Random slave latency 0..4 per access
        randLat = 1'b1;
        expSum = '0;
        for (int i = 0; i < 128; i++) begin
            rom[i] = 16'($urandom);
            expSum = expSum + rom[i];
        end
        wrBase = writeCount;
        applyStimulus(1'b0, base);
        waitDone(1'b0, 3000, base, elapsed, rstBefore);
        checkOutput("rlDone", doneA, 1);
        checkOutput("rlChk", chkA, expSum);
        checkOutput("rlWrites", writeCount - wrBase, 128);
        checkRam("rlRam");
        checkOutput("badAccess", badCount, 0);

        // One-word instance: 3-cycle ack, then random fixed latencies
        @(negedge clock);
        rstBN = 1'b1;
        base = cycleCnt;
        waitDone(1'b1, 100, base, elapsed, rstBefore);
        checkOutput("w1DoneCycle", elapsed, 11);
        checkOutput("w1Ram", ramB, 16'hBEEF);
        checkOutput("w1Chk", chkB, 16'hBEEF);
        checkOutput("w1Count", {writesB[7:0], readsB[7:0]}, 16'h0101);
        checkOutput("w1CpuRst", cpuRstB, 0);
        for (int r = 0; r < 4; r++) begin
            latB = int'($urandom_range(0, 4));
            romB = 16'($urandom);
            applyStimulus(1'b1, base);
            waitDone(1'b1, 100, base, elapsed, rstBefore);
            checkOutput($sformatf("w1Lat%0dCycle", latB), elapsed, 2 * latB + 6);
            checkOutput($sformatf("w1Lat%0dRam", latB), ramB, romB);
            checkOutput($sformatf("w1Lat%0dChk", latB), chkB, romB);
        end
        checkOutput("w1Err", errB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
